// File: rtl/mem_wb_stage_if.sv
// Two-beat, 16-bit data-memory handshake between the MEM/WB stage (master) and data memory (slave).
interface mem_wb_stage_if #(
    parameter int ADDR_W = 17
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic [15:0]       mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mem_wb_stage.sv
// ARM memory/writeback stage: 32-bit loads/stores as two 16-bit beats, freezing upstream meanwhile.
// Optional freeze-cycle counter enabled by defining STALL_CNT_EN.
module mem_wb_stage #(
    parameter logic [31:0] MEM_BASE = 32'd1024,
    parameter int          ADDR_W   = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_en,
    input  logic                  mem_r_en,
    input  logic                  mem_w_en,
    input  logic [31:0]           alu_result,
    input  logic [31:0]           val_rm,
    input  logic [3:0]            dest,
    mem_wb_stage_if.master        mem_bus,
    output logic                  freeze,
    output logic                  write_back_in,
    output logic [3:0]            dest_wb,
    output logic [31:0]           result_wb,
    output logic [31:0]           stall_cycles
);
    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t      state_reg, state_next;
    logic [31:0] rbuf_reg;
    logic        wb_reg;
    logic [3:0]  dest_reg;
    logic [31:0] result_reg;

    logic        mem_op;
    logic        busy;
    logic        half;
    logic [31:0] word;

    assign mem_op = mem_r_en | mem_w_en;
    assign word   = (alu_result - MEM_BASE) >> 2;

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        half       = 1'b0;
        case (state_reg)
            IDLE: if (mem_op) state_next = LO;
            LO: begin
                busy = 1'b1;
                if (mem_bus.mem_ready) state_next = HI;
            end
            HI: begin
                busy = 1'b1;
                half = 1'b1;
                if (mem_bus.mem_ready) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign mem_bus.mem_req   = busy;
    assign mem_bus.mem_we    = busy & mem_w_en;
    assign mem_bus.mem_addr  = ADDR_W'({word, half});
    assign mem_bus.mem_wdata = !busy ? 16'h0000 : (half ? val_rm[31:16] : val_rm[15:0]);

    // Gated by reset so a pending op on the inputs cannot hold the pipeline during reset.
    assign freeze = rst & (busy | ((state_reg == IDLE) & mem_op));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            rbuf_reg   <= '0;
            wb_reg     <= 1'b0;
            dest_reg   <= '0;
            result_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == LO && mem_bus.mem_ready) rbuf_reg[15:0]  <= mem_bus.mem_rdata;
            if (state_reg == HI && mem_bus.mem_ready) rbuf_reg[31:16] <= mem_bus.mem_rdata;
            if (freeze) begin
                wb_reg <= 1'b0;
            end else begin
                wb_reg     <= wb_en;
                dest_reg   <= dest;
                result_reg <= (state_reg == DONE && mem_r_en) ? rbuf_reg : alu_result;
            end
        end
    end

    assign write_back_in = wb_reg;
    assign dest_wb       = dest_reg;
    assign result_wb     = result_reg;

`ifdef STALL_CNT_EN
    logic [31:0] stall_reg;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        stall_reg <= '0;
        else if (freeze) stall_reg <= stall_reg + 32'd1;
    end
    assign stall_cycles = stall_reg;
`else
    assign stall_cycles = 32'd0;
`endif
endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed plan cases plus randomized ops against a memory model.
module tb_mem_wb_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        wb_en, mem_r_en, mem_w_en;
    logic [31:0] alu_result, val_rm;
    logic [3:0]  dest;
    logic        freeze, write_back_in;
    logic [3:0]  dest_wb;
    logic [31:0] result_wb, stall_cycles;

    always #5 clk = ~clk;

    mem_wb_stage_if #(.ADDR_W(17)) bus ();

    mem_wb_stage #(.MEM_BASE(32'd1024), .ADDR_W(17)) dut (
        .clk(clk), .rst(rst), .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .alu_result(alu_result), .val_rm(val_rm), .dest(dest), .mem_bus(bus),
        .freeze(freeze), .write_back_in(write_back_in), .dest_wb(dest_wb),
        .result_wb(result_wb), .stall_cycles(stall_cycles)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int stall_exp = 0;

    logic [15:0] mem_model [int];

    // Observations collected by run_op for the calling test to judge.
    int          obs_freeze, obs_beats, obs_unstable, obs_bubble_bad, obs_bad_ctl;
    logic [16:0] obs_addr [2];
    logic        obs_we [2];
    logic [15:0] obs_wdata [2];
    logic        obs_wb, obs_timeout;
    logic [3:0]  obs_dest;
    logic [31:0] obs_res;

    function automatic logic [15:0] mem_read(int a);
        if (mem_model.exists(a)) return mem_model[a];
        return 16'((a * 40503) ^ 23130);
    endfunction

    function automatic int stall_ref();
`ifdef STALL_CNT_EN
        return stall_exp;
`else
        return 0;
`endif
    endfunction

    function automatic logic [16:0] beat_addr(logic [31:0] alu, int beat);
        logic [31:0] w;
        w = (alu - 32'd1024) / 4;
        return 17'(((w * 2) + beat) % 131072);
    endfunction

    // Presents one instruction (entered just after a falling edge) and plays data memory until it retires.
    task automatic run_op(input logic r, input logic w, input logic wbe, input logic [3:0] d,
                          input logic [31:0] alu, input logic [31:0] vrm, input int w0, input int w1);
        int   wait_left;
        bit   fresh;
        logic frz_now;
        mem_r_en = r; mem_w_en = w; wb_en = wbe; dest = d; alu_result = alu; val_rm = vrm;
        obs_freeze = 0; obs_beats = 0; obs_unstable = 0; obs_bubble_bad = 0; obs_bad_ctl = 0;
        obs_timeout = 1'b1; wait_left = w0; fresh = 1'b1;
        for (int i = 0; i < 2; i++) begin obs_addr[i] = 'x; obs_we[i] = 1'bx; obs_wdata[i] = 'x; end
        for (int cyc = 0; cyc < 60; cyc++) begin
            #1;
            if (bus.mem_req) begin
                if (!freeze) obs_bad_ctl++;
                if (obs_beats < 2) begin
                    if (fresh) begin
                        obs_addr[obs_beats] = bus.mem_addr; obs_we[obs_beats] = bus.mem_we;
                        obs_wdata[obs_beats] = bus.mem_wdata; fresh = 1'b0;
                    end else if (bus.mem_addr !== obs_addr[obs_beats] || bus.mem_we !== obs_we[obs_beats]
                                 || bus.mem_wdata !== obs_wdata[obs_beats]) begin
                        obs_unstable++;
                    end
                end
                if (wait_left > 0) begin
                    bus.mem_ready = 1'b0; wait_left--;
                end else begin
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = mem_read(int'(bus.mem_addr));
                    if (bus.mem_we) mem_model[int'(bus.mem_addr)] = bus.mem_wdata;
                    obs_beats++; fresh = 1'b1; wait_left = w1;
                end
            end else begin
                bus.mem_ready = 1'($urandom_range(0, 1));
                bus.mem_rdata = 16'($urandom);
            end
            frz_now = freeze;
            if (frz_now) obs_freeze++;
            @(posedge clk); #1;
            if (frz_now) begin
                if (write_back_in !== 1'b0) obs_bubble_bad++;
            end else begin
                obs_wb = write_back_in; obs_dest = dest_wb; obs_res = result_wb; obs_timeout = 1'b0;
            end
            @(negedge clk);
            bus.mem_ready = 1'b0;
            if (!obs_timeout) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; wb_en = 1'b0; mem_w_en = 1'b0; dest = 4'd0; alu_result = 32'd1024; val_rm = '0;
        mem_r_en = 1'b1;
        bus.mem_ready = 1'b1; bus.mem_rdata = 16'hFFFF;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({bus.mem_req, freeze, write_back_in, dest_wb, result_wb, stall_cycles} !== '0) begin
            n_fail++;
            $display("FAIL reset_state got req=%0b frz=%0b wb=%0b dest=%0d res=%h stall=%0d required all zero",
                     bus.mem_req, freeze, write_back_in, dest_wb, result_wb, stall_cycles);
        end
        mem_r_en = 1'b0; bus.mem_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        stall_exp = 0;
        $display("reset: outputs idle while rst low");
    endtask

    task automatic test_alu();
        run_op(1'b0, 1'b0, 1'b1, 4'd3, 32'h0000_00AB, 32'h1111_2222, 0, 0);
        n_checks++;
        if ({obs_timeout, obs_wb, obs_dest, obs_res} !== {1'b0, 1'b1, 4'd3, 32'h0000_00AB}) begin
            n_fail++;
            $display("FAIL alu_wb got to=%0b wb=%0b dest=%0d res=%h required 0/1/3/000000ab",
                     obs_timeout, obs_wb, obs_dest, obs_res);
        end
        n_checks++;
        if (obs_freeze !== 0 || obs_beats !== 0) begin
            n_fail++; $display("FAIL alu_nofreeze got freeze=%0d beats=%0d required 0/0", obs_freeze, obs_beats);
        end
        n_checks++;
        if (stall_cycles !== stall_ref()) begin
            n_fail++; $display("FAIL alu_stall got %0d required %0d", stall_cycles, stall_ref());
        end
        $display("alu: wb=%0b dest=%0d res=%h", obs_wb, obs_dest, obs_res);
    endtask

    task automatic test_store();
        run_op(1'b0, 1'b1, 1'b0, 4'd7, 32'd1028, 32'hDEAD_BEEF, 0, 0);
        stall_exp += 3;
        n_checks++;
        if ({obs_beats, obs_addr[0], obs_addr[1], obs_we[0], obs_we[1]} !== {32'd2, 17'd2, 17'd3, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL store_beats got n=%0d a=%0d,%0d we=%0b,%0b required 2 a=2,3 we=1,1",
                     obs_beats, obs_addr[0], obs_addr[1], obs_we[0], obs_we[1]);
        end
        n_checks++;
        if ({obs_wdata[0], obs_wdata[1]} !== {16'hBEEF, 16'hDEAD}) begin
            n_fail++; $display("FAIL store_wdata got %h,%h required beef,dead", obs_wdata[0], obs_wdata[1]);
        end
        n_checks++;
        if (obs_freeze !== 3 || obs_bubble_bad !== 0 || obs_bad_ctl !== 0) begin
            n_fail++; $display("FAIL store_freeze got freeze=%0d bubble_bad=%0d ctl_bad=%0d required 3/0/0",
                               obs_freeze, obs_bubble_bad, obs_bad_ctl);
        end
        n_checks++;
        if ({obs_timeout, obs_wb, obs_dest, obs_res} !== {1'b0, 1'b0, 4'd7, 32'd1028}) begin
            n_fail++; $display("FAIL store_wb got to=%0b wb=%0b dest=%0d res=%h required 0/0/7/00000404",
                               obs_timeout, obs_wb, obs_dest, obs_res);
        end
        n_checks++;
        if (stall_cycles !== stall_ref()) begin
            n_fail++; $display("FAIL store_stall got %0d required %0d", stall_cycles, stall_ref());
        end
        $display("store: freeze=%0d addrs=%0d,%0d wdata=%h,%h", obs_freeze, obs_addr[0], obs_addr[1],
                 obs_wdata[0], obs_wdata[1]);
    endtask

    task automatic test_load_waits();
        mem_model[4] = 16'h5678;
        mem_model[5] = 16'h1234;
        run_op(1'b1, 1'b0, 1'b1, 4'd5, 32'd1032, 32'($urandom), 2, 2);
        stall_exp += 7;
        n_checks++;
        if ({obs_beats, obs_addr[0], obs_addr[1], obs_we[0], obs_we[1], obs_unstable}
            !== {32'd2, 17'd4, 17'd5, 1'b0, 1'b0, 32'd0}) begin
            n_fail++; $display("FAIL load_beats got n=%0d a=%0d,%0d we=%0b,%0b unstable=%0d required 2 a=4,5 we=0,0 0",
                               obs_beats, obs_addr[0], obs_addr[1], obs_we[0], obs_we[1], obs_unstable);
        end
        n_checks++;
        if (obs_freeze !== 7 || obs_bubble_bad !== 0) begin
            n_fail++; $display("FAIL load_freeze got %0d bubble_bad=%0d required 7/0", obs_freeze, obs_bubble_bad);
        end
        n_checks++;
        if ({obs_timeout, obs_wb, obs_dest, obs_res} !== {1'b0, 1'b1, 4'd5, 32'h1234_5678}) begin
            n_fail++; $display("FAIL load_wb got to=%0b wb=%0b dest=%0d res=%h required 0/1/5/12345678",
                               obs_timeout, obs_wb, obs_dest, obs_res);
        end
        n_checks++;
        if (stall_cycles !== stall_ref()) begin
            n_fail++; $display("FAIL load_stall got %0d required %0d", stall_cycles, stall_ref());
        end
        $display("load: freeze=%0d res=%h", obs_freeze, obs_res);
    endtask

    // One randomized op, judged against the memory model and the addressing/latency rules.
    task automatic test_random_op(input int kind, input string tag);
        logic        r, w, wbe;
        logic [3:0]  d;
        logic [31:0] alu, vrm, exp_res;
        int          w0, w1, exp_frz;
        logic [16:0] a0, a1;
        r = (kind == 1); w = (kind == 2); wbe = 1'($urandom); d = 4'($urandom);
        alu = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'd1024 + 32'($urandom_range(0, 511));
        vrm = 32'($urandom); w0 = $urandom_range(0, 3); w1 = $urandom_range(0, 3);
        a0 = beat_addr(alu, 0); a1 = beat_addr(alu, 1);
        exp_res = r ? {mem_read(int'(a1)), mem_read(int'(a0))} : alu;
        exp_frz = (kind == 0) ? 0 : 3 + w0 + w1;
        run_op(r, w, wbe, d, alu, vrm, w0, w1);
        stall_exp += exp_frz;
        n_checks++;
        if ({obs_timeout, obs_wb, obs_dest, obs_res} !== {1'b0, wbe, d, exp_res}) begin
            n_fail++; $display("FAIL %s_wb got to=%0b wb=%0b dest=%0d res=%h required 0/%0b/%0d/%h",
                               tag, obs_timeout, obs_wb, obs_dest, obs_res, wbe, d, exp_res);
        end
        n_checks++;
        if (obs_freeze !== exp_frz || obs_bubble_bad !== 0 || obs_bad_ctl !== 0 || obs_unstable !== 0) begin
            n_fail++; $display("FAIL %s_ctl got freeze=%0d bub=%0d ctl=%0d unst=%0d required %0d/0/0/0",
                               tag, obs_freeze, obs_bubble_bad, obs_bad_ctl, obs_unstable, exp_frz);
        end
        if (kind != 0) begin
            n_checks++;
            if ({obs_beats, obs_addr[0], obs_addr[1], obs_we[0], obs_we[1]} !== {32'd2, a0, a1, w, w}) begin
                n_fail++; $display("FAIL %s_beats got n=%0d a=%0d,%0d we=%0b,%0b required 2 a=%0d,%0d we=%0b",
                                   tag, obs_beats, obs_addr[0], obs_addr[1], obs_we[0], obs_we[1], a0, a1, w);
            end
            n_checks++;
            if (w && {obs_wdata[0], obs_wdata[1]} !== {vrm[15:0], vrm[31:16]}) begin
                n_fail++; $display("FAIL %s_wdata got %h,%h required %h,%h", tag,
                                   obs_wdata[0], obs_wdata[1], vrm[15:0], vrm[31:16]);
            end
        end
        n_checks++;
        if (stall_cycles !== stall_ref()) begin
            n_fail++; $display("FAIL %s_stall got %0d required %0d", tag, stall_cycles, stall_ref());
        end
        $display("%s: kind=%0d alu=%h freeze=%0d wb=%0b dest=%0d res=%h", tag, kind, alu, obs_freeze,
                 obs_wb, obs_dest, obs_res);
    endtask

    task automatic test_back_to_back();
        test_random_op(1, "b2b_load");
        test_random_op(2, "b2b_store");
        test_random_op(1, "b2b_load2");
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) test_random_op($urandom_range(0, 2), "rand");
    endtask

    task automatic test_reset_mid();
        mem_r_en = 1'b1; mem_w_en = 1'b0; wb_en = 1'b1; dest = 4'd9; alu_result = 32'd1040; val_rm = '0;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        bus.mem_ready = 1'b1; bus.mem_rdata = 16'hAAAA;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({bus.mem_req, freeze, write_back_in} !== 3'b000) begin
            n_fail++; $display("FAIL midreset_now got req=%0b frz=%0b wb=%0b required 0/0/0",
                               bus.mem_req, freeze, write_back_in);
        end
        mem_r_en = 1'b0; wb_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        stall_exp = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({bus.mem_req, freeze, write_back_in} !== 3'b000) begin
                n_fail++; $display("FAIL midreset_after got req=%0b frz=%0b wb=%0b required 0/0/0",
                                   bus.mem_req, freeze, write_back_in);
            end
        end
        @(negedge clk);
        test_random_op(0, "post_reset");
        $display("reset_mid: access abandoned, pipeline resumed");
    endtask

    initial begin
        test_reset();
        test_alu();
        test_store();
        test_load_waits();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
